// File: rtl/addsub_chunk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : addsub_chunk_ctrl_pkg
// Brief  : Shared definitions for the chunk-serial add/subtract controller.
//          It holds the FSM state encoding and the operation mode constants.
// Rev    : 1.0  initial release
// ============================================================================
package addsub_chunk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/addsub_chunk_ctrl_chunk.sv
`default_nettype none
// ============================================================================
// Module : addsub_chunk
// Brief  : Combinational W-bit adder slice with carry in. It provides the sum,
//          the carry out of the MSB, and the carry into the MSB. The controller
//          needs the carry into the MSB for signed overflow detection.
// Ports  : a, b   - W-bit addends (b is already inverted by the caller for a
//                   subtract)
//          cin    - carry in
//          sum    - W-bit sum
//          cout   - carry out of bit W-1
//          cmsb   - carry into bit W-1
// Rev    : 1.0  initial release
// ============================================================================
module addsub_chunk
    import addsub_chunk_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum    = w_full[W-1:0];
    assign cout   = w_full[W];
    // The sum bit is a ^ b ^ carry-in, so the carry into the MSB can be
    // recovered from the MSB sum bit without a second adder.
    assign cmsb   = w_full[W-1] ^ a[W-1] ^ b[W-1];

endmodule
`default_nettype wire

// File: rtl/addsub_chunk_ctrl.sv
`default_nettype none
// ============================================================================
// Module : addsub_chunk_ctrl
// Brief  : Multi-cycle add/subtract unit. It processes CHUNK bits per cycle,
//          least significant chunk first, and uses a single shared chunk adder.
// Ports  : clock, reset       - clock and asynchronous active-high reset
//          start, mode, a, b  - request, 0=add / 1=sub, and operands
//                               (all sampled in IDLE)
//          busy               - high while an operation is in flight
//                               (LOAD/RUN/DONE)
//          done               - one-cycle completion pulse (DONE state)
//          result, cout, ovf  - registered result, carry (1 = no borrow on a
//                               subtract), and signed overflow
// WIDTH must be a positive multiple of CHUNK.
// Rev    : 1.0  initial release
// ============================================================================
module addsub_chunk_ctrl
    import addsub_chunk_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NCHUNK - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_work;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_cmsb;
    logic [WIDTH-1:0]   w_work_next;

    // The index register selects the active chunk, so one adder serves every
    // chunk position. A subtract is computed as a + ~b + 1; the +1 comes from
    // the carry, which is seeded with the mode bit in LOAD.
    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK] ^ {CHUNK{r_mode == MODE_SUB}};

    addsub_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // Working register with the current chunk merged in. It is used both as
    // the next working value and, on the last chunk, as the final result.
    always_comb begin
        w_work_next = r_work;
        w_work_next[r_idx*CHUNK +: CHUNK] = w_sum;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_work  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        busy    <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_idx   <= '0;
                    r_carry <= r_mode;
                    r_work  <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_cout;
                    if (r_idx == c_LAST) begin
                        // On the last chunk, the chunk's MSB is bit WIDTH-1,
                        // so its carries give the word-level overflow.
                        result  <= w_work_next;
                        cout    <= w_cout;
                        ovf     <= w_cmsb ^ w_cout;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_chunk_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_addsub_chunk_ctrl
// Brief  : Self-checking bench for addsub_chunk_ctrl. It uses a 16/4 instance
//          for the main vectors and sequences, and an 8/8 instance for the
//          single-chunk case.
// Rev    : 1.0  initial release
// ============================================================================
module tb_addsub_chunk_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    logic        start8;
    logic        mode8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  result8;
    logic        cout8;
    logic        ovf8;

    int n_checks = 0;
    int n_errors = 0;

    addsub_chunk_ctrl #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    addsub_chunk_ctrl #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clock  (clock),
        .reset  (reset),
        .start  (start8),
        .mode   (mode8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .cout   (cout8),
        .ovf    (ovf8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        m;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Starts an op from IDLE; the next edge is the capture edge. After that
    // edge the operands are scrambled so that late input changes are visible.
    task automatic run_op(input logic m, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic eco, input logic eov,
                          input string tag);
        int lat;
        logic [15:0] prev;
        logic early;
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        prev  = result;
        early = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        a     = ~x;
        b     = x ^ y ^ 16'h5A5A;
        mode  = ~m;
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (result !== prev) early = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat), 32'd5);
        chk({tag, " early_update"}, {31'd0, early}, 32'd0);
        chk({tag, " result"}, {16'd0, result}, {16'd0, er});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, eco});
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eov});
        @(posedge clock); #1;
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run8(input logic m, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic eco, input logic eov,
                        input string tag);
        int lat;
        mode8  = m;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        a8     = ~x;
        lat    = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " result"}, {24'd0, result8}, {24'd0, er});
        chk({tag, " cout"}, {31'd0, cout8}, {31'd0, eco});
        chk({tag, " ovf"}, {31'd0, ovf8}, {31'd0, eov});
        @(posedge clock); #1;
        chk({tag, " done_pulse"}, {31'd0, done8}, 32'd0);
    endtask

    initial begin
        int ndone;
        int nbusy;
        int nidle;
        int idle_at;
        logic found;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        mode8  = 1'b0;
        a8     = '0;
        b8     = '0;

        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", {16'd0, result}, 32'd0);
        chk("reset cout", {31'd0, cout}, 32'd0);
        chk("reset ovf", {31'd0, ovf}, 32'd0);
        chk("reset busy8", {31'd0, busy8}, 32'd0);

        // The first op is driven before the first edge with reset low.
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].co, vecs[i].ov,
                   $sformatf("vec%0d", i));

        // Outputs hold while idle.
        repeat (3) @(posedge clock);
        #1;
        chk("hold result", {16'd0, result}, 32'h0002);
        chk("hold cout", {31'd0, cout}, 32'd1);

        // Start pulses during RUN and at the DONE->IDLE edge are dropped.
        mode  = 1'b0;
        a     = 16'h0001;
        b     = 16'h0002;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ndone = 0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (done) begin
                ndone++;
                found = 1'b1;
                break;
            end
        end
        chk("ignore done_seen", {31'd0, found}, 32'd1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("ignore idle_after_done", {31'd0, busy}, 32'd0);
        nbusy = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("ignore done_count", 32'(ndone), 32'd1);
        chk("ignore no_queue", 32'(nbusy), 32'd0);
        chk("ignore result", {16'd0, result}, 32'h0003);

        // With start held high, ops run back to back with one IDLE cycle.
        mode  = 1'b0;
        a     = 16'hFFF0;
        b     = 16'h0020;
        start = 1'b1;
        @(posedge clock); #1;
        nidle   = 0;
        idle_at = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock); #1;
            if (!busy) begin
                nidle++;
                idle_at = k;
            end
        end
        start = 1'b0;
        chk("held idle_count", 32'(nidle), 32'd1);
        chk("held idle_cycle", 32'(idle_at), 32'd6);
        chk("held second_busy", {31'd0, busy}, 32'd1);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("held second_done", {31'd0, found}, 32'd1);
        chk("held result", {16'd0, result}, 32'h0010);
        chk("held cout", {31'd0, cout}, 32'd1);
        @(posedge clock); #1;

        // Reset in the third RUN cycle aborts the op immediately.
        mode  = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", {16'd0, result}, 32'd0);
        chk("abort cout", {31'd0, cout}, 32'd0);
        chk("abort ovf", {31'd0, ovf}, 32'd0);
        #2;
        reset = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        chk("abort stays_idle", 32'(nbusy), 32'd0);
        chk("abort result_after", {16'd0, result}, 32'd0);
        run_op(1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, "post_abort");

        // Single-chunk instance.
        run8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "w8 add");
        run8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "w8 sub");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
